euler_update_engine: RTL and testbench

//  Responder end of the Euler_Enable/Euler_End handshake driven by the step module.
//  On request, reads state vector X and derivative vector dX from the step RAM and

---
 rtl/euler_pkg.sv | 22 ++
 rtl/euler_update_engine_if.sv | 31 +++
 rtl/euler_sat_add.sv | 38 +++
 rtl/euler_update_engine.sv | 128 ++++++++++++
 tb/tb_euler_update_engine.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/euler_pkg.sv
// Shared types and constants for the Euler update engine.
//  state_e      : FSM state encoding
//  DefAddrWidth : default RAM address width
//  DefDataWidth : default signed data word width
//  DefSatMax/Min: saturation limits for the default data width
package euler_pkg;

   localparam int unsigned DefAddrWidth = 13;
   localparam int unsigned DefDataWidth = 64;

   localparam logic [DefDataWidth-1:0] DefSatMax = {1'b0, {(DefDataWidth-1){1'b1}}};
   localparam logic [DefDataWidth-1:0] DefSatMin = {1'b1, {(DefDataWidth-1){1'b0}}};

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWrite,
      StDone,
      StWaitLow
   } state_e;

endpackage

// File: rtl/euler_update_engine_if.sv
// Handshake and step-RAM bus between the step module / RAM and the Euler engine.
//  master : step module and RAM side (drives request, length, shift, read data)
//  slave  : engine side (drives completion, error, addresses, write-back)
interface euler_update_engine_if #(
   parameter int unsigned AW = 13,
   parameter int unsigned DW = 64
);
   logic          Euler_Enable;
   logic          Euler_End;
   logic          Error_Flag;
   logic [AW-1:0] Vector_Length;
   logic [5:0]    H_Shift;
   logic [AW-1:0] RD1_Address;
   logic [DW-1:0] RD1_Data;
   logic [AW-1:0] RD2_Address;
   logic [DW-1:0] RD2_Data;
   logic [AW-1:0] WR_Address;
   logic [DW-1:0] WR_Data;
   logic          WR_Enable;

   modport master (
      output Euler_Enable, Vector_Length, H_Shift, RD1_Data, RD2_Data,
      input  Euler_End, Error_Flag, RD1_Address, RD2_Address, WR_Address, WR_Data, WR_Enable
   );

   modport slave (
      input  Euler_Enable, Vector_Length, H_Shift, RD1_Data, RD2_Data,
      output Euler_End, Error_Flag, RD1_Address, RD2_Address, WR_Address, WR_Data, WR_Enable
   );

endinterface

// File: rtl/euler_sat_add.sv
// Combinational x + (dx >>> shift) with signed saturation.
//  x_i     : signed addend (state element)
//  dx_i    : signed derivative, arithmetically shifted right by shift_i
//  shift_i : shift amount; amounts >= DW collapse to the sign of dx_i
//  sum_o   : saturated sum
//  ovf_o   : high when the sum was clamped
module euler_sat_add #(
   parameter int unsigned DW = 64
) (
   input  logic [DW-1:0] x_i,
   input  logic [DW-1:0] dx_i,
   input  logic [5:0]    shift_i,
   output logic [DW-1:0] sum_o,
   output logic          ovf_o
);

   logic signed [DW-1:0] dx_shifted;
   logic [DW:0]          wide;

   always_comb begin
      if (32'(shift_i) >= DW) begin
         dx_shifted = {DW{dx_i[DW-1]}};
      end else begin
         dx_shifted = $signed(dx_i) >>> shift_i;
      end
      // One guard bit: overflow shows up as disagreement of the top two bits.
      wide  = {x_i[DW-1], x_i} + {dx_shifted[DW-1], dx_shifted};
      ovf_o = wide[DW] ^ wide[DW-1];
      if (!ovf_o) begin
         sum_o = wide[DW-1:0];
      end else if (wide[DW]) begin
         sum_o = {1'b1, {(DW-1){1'b0}}};
      end else begin
         sum_o = {1'b0, {(DW-1){1'b1}}};
      end
   end

endmodule

// File: rtl/euler_update_engine.sv
// Euler update engine: responder to Euler_Enable/Euler_End. For i in 0..N-1 it reads
// X[i] and dX[i] from the step RAM and writes back sat(X[i] + (dX[i] >>> H_Shift)).
//  CLK : clock, rising edge
//  RST : asynchronous active-low reset
//  bus : slave side of euler_update_engine_if (handshake, length/shift, RAM ports)
// One element takes two cycles (READ presents addresses, WRITE consumes the data).
module euler_update_engine
   import euler_pkg::*;
#(
   parameter int unsigned RAM_ADDRESS_WIDTH = DefAddrWidth,
   parameter int unsigned DATA_WIDTH        = DefDataWidth,
   parameter int unsigned X_BASE            = 0,
   parameter int unsigned DX_BASE           = 100
) (
   input logic                 CLK,
   input logic                 RST,
   euler_update_engine_if.slave bus
);

   localparam logic [RAM_ADDRESS_WIDTH-1:0] XBase  = RAM_ADDRESS_WIDTH'(X_BASE);
   localparam logic [RAM_ADDRESS_WIDTH-1:0] DxBase = RAM_ADDRESS_WIDTH'(DX_BASE);

   state_e                       state_q, state_d;
   logic [RAM_ADDRESS_WIDTH-1:0] idx_q, idx_d;
   logic [RAM_ADDRESS_WIDTH-1:0] n_q, n_d;
   logic [5:0]                   shift_q, shift_d;
   logic                         err_q, err_d;

   logic [DATA_WIDTH-1:0] sum;
   logic                  ovf;
   logic                  last;

   assign last = (idx_q == n_q - RAM_ADDRESS_WIDTH'(1));

   euler_sat_add #(
      .DW (DATA_WIDTH)
   ) u_sat_add (
      .x_i     (bus.RD1_Data),
      .dx_i    (bus.RD2_Data),
      .shift_i (shift_q),
      .sum_o   (sum),
      .ovf_o   (ovf)
   );

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= StIdle;
         idx_q   <= '0;
         n_q     <= '0;
         shift_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         shift_q <= shift_d;
         err_q   <= err_d;
      end
   end

   // Next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.Euler_Enable) begin
               state_d = (bus.Vector_Length == '0) ? StDone : StRead;
            end
         end
         StRead:    state_d = StWrite;
         StWrite:   state_d = last ? StDone : StRead;
         StDone:    state_d = StWaitLow;
         // Requires an Enable low phase before another run can start.
         StWaitLow: if (!bus.Euler_Enable) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Index, latched run parameters and sticky saturation flag.
   always_comb begin
      idx_d   = idx_q;
      n_d     = n_q;
      shift_d = shift_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.Euler_Enable) begin
               n_d     = bus.Vector_Length;
               shift_d = bus.H_Shift;
               err_d   = 1'b0;
               idx_d   = '0;
            end
         end
         StWrite: begin
            if (ovf) err_d = 1'b1;
            if (!last) idx_d = idx_q + RAM_ADDRESS_WIDTH'(1);
         end
         default: ;
      endcase
   end

   // Outputs decoded from the registered state; everything idles at zero.
   always_comb begin
      bus.RD1_Address = '0;
      bus.RD2_Address = '0;
      bus.WR_Address  = '0;
      bus.WR_Data     = '0;
      bus.WR_Enable   = 1'b0;
      bus.Euler_End   = 1'b0;
      unique case (state_q)
         StRead: begin
            bus.RD1_Address = XBase + idx_q;
            bus.RD2_Address = DxBase + idx_q;
         end
         StWrite: begin
            bus.WR_Enable  = 1'b1;
            bus.WR_Address = XBase + idx_q;
            bus.WR_Data    = sum;
         end
         StDone:  bus.Euler_End = 1'b1;
         default: ;
      endcase
   end

   assign bus.Error_Flag = err_q;

endmodule

// File: tb/tb_euler_update_engine.sv
// Directed bench for euler_update_engine with a write-back scoreboard and RAM model.
module tb_euler_update_engine;
   import euler_pkg::*;

   localparam int unsigned Aw  = 13;
   localparam int unsigned Dw  = 64;
   localparam int unsigned XB  = 0;
   localparam int unsigned DXB = 100;

   typedef struct {
      logic [Aw-1:0] a;
      logic [Dw-1:0] d;
   } wr_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   wr_count = 0;
   wr_t  sbq[$];
   logic [Dw-1:0] mem[0:255];
   logic [Dw-1:0] exp_x[0:255];

   euler_update_engine_if #(.AW(Aw), .DW(Dw)) bus ();

   euler_update_engine #(
      .RAM_ADDRESS_WIDTH (Aw),
      .DATA_WIDTH        (Dw),
      .X_BASE            (XB),
      .DX_BASE           (DXB)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Step RAM: synchronous read, synchronous write.
   always @(posedge CLK) begin
      bus.RD1_Data <= mem[bus.RD1_Address[7:0]];
      bus.RD2_Data <= mem[bus.RD2_Address[7:0]];
      if (bus.WR_Enable) mem[bus.WR_Address[7:0]] <= bus.WR_Data;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the next expected write.
   always @(negedge CLK) begin
      if (bus.WR_Enable) begin
         wr_t e;
         wr_count++;
         chk("wr_pending", 64'(sbq.size() != 0), 64'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("wr_addr", 64'(bus.WR_Address), 64'(e.a));
            chk("wr_data", bus.WR_Data, e.d);
         end
      end
   end

   function automatic void model(input logic [63:0] x, input logic [63:0] dx, input int h,
                                 output logic [63:0] r, output bit o);
      logic signed [63:0] sh;
      logic [63:0]        s;
      if (h >= 64) sh = dx[63] ? '1 : '0;
      else         sh = $signed(dx) >>> h;
      s = x + sh;
      o = (x[63] == sh[63]) && (s[63] != x[63]);
      r = o ? (x[63] ? DefSatMin : DefSatMax) : s;
   endfunction

   task automatic do_run(input int n, input int h, input bit hold_high);
      bit          ef;
      bit          o;
      logic [63:0] v;
      int          lat;
      int          wr0;
      ef = 0;
      for (int i = 0; i < n; i++) begin
         model(mem[XB+i], mem[DXB+i], h, v, o);
         exp_x[i] = v;
         ef |= o;
         sbq.push_back('{a: Aw'(XB + i), d: v});
      end
      wr0 = wr_count;
      @(negedge CLK);
      bus.Euler_Enable  = 1'b1;
      bus.Vector_Length = Aw'(n);
      bus.H_Shift       = 6'(h);
      lat = 0;
      do begin
         @(negedge CLK);
         lat++;
      end while (!bus.Euler_End && lat < 200);
      chk("latency", 64'(lat), 64'(2 * n + 1));
      chk("err_flag", 64'(bus.Error_Flag), 64'(ef));
      chk("wr_count", 64'(wr_count - wr0), 64'(n));
      @(negedge CLK);
      chk("end_pulse", 64'(bus.Euler_End), 64'd0);
      chk("sb_empty", 64'(sbq.size()), 64'd0);
      for (int i = 0; i < n; i++) chk("x_mem", mem[XB+i], exp_x[i]);
      if (!hold_high) bus.Euler_Enable = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      int ends;
      int wr0;
      int k;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      bus.Euler_Enable  = 1'b0;
      bus.Vector_Length = '0;
      bus.H_Shift       = '0;

      // Reset state.
      #12;
      chk("rst_end", 64'(bus.Euler_End), 64'd0);
      chk("rst_wren", 64'(bus.WR_Enable), 64'd0);
      chk("rst_err", 64'(bus.Error_Flag), 64'd0);
      chk("rst_rd1", 64'(bus.RD1_Address), 64'd0);
      chk("rst_wrdata", bus.WR_Data, 64'd0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      // Basic three-element run.
      mem[XB+0] = 64'd10; mem[XB+1] = 64'd20; mem[XB+2] = 64'd30;
      mem[DXB+0] = 64'd4; mem[DXB+1] = 64'd8; mem[DXB+2] = -64'sd16;
      do_run(3, 2, 1'b0);
      chk("basic_x0", mem[XB+0], 64'd11);
      chk("basic_x2", mem[XB+2], 64'd26);

      // Empty vector: End after one cycle, no writes.
      do_run(0, 0, 1'b0);

      // Positive saturation, then a clean run clears the flag.
      mem[XB+0] = DefSatMax; mem[DXB+0] = 64'd1;
      do_run(1, 0, 1'b0);
      chk("pos_sat", mem[XB+0], 64'h7fff_ffff_ffff_ffff);
      mem[XB+0] = 64'd5; mem[DXB+0] = 64'd3;
      do_run(1, 0, 1'b0);
      chk("clean_x0", mem[XB+0], 64'd8);

      // Negative saturation.
      mem[XB+0] = DefSatMin; mem[DXB+0] = -64'sd8;
      do_run(1, 1, 1'b0);
      chk("neg_sat", mem[XB+0], 64'h8000_0000_0000_0000);

      // Largest shift: negative dX gives -1, positive gives 0.
      mem[XB+0] = 64'd100; mem[DXB+0] = -64'sd7;
      mem[XB+1] = 64'd5;   mem[DXB+1] = 64'h4000_0000_0000_0000;
      do_run(2, 63, 1'b0);
      chk("shift63_x0", mem[XB+0], 64'd99);

      // Enable held high after End: no restart; drop and raise runs again.
      mem[XB+0] = 64'd1; mem[DXB+0] = 64'd2;
      do_run(1, 0, 1'b1);
      ends = 0;
      wr0  = wr_count;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (bus.Euler_End) ends++;
      end
      chk("hold_no_end", 64'(ends), 64'd0);
      chk("hold_no_wr", 64'(wr_count - wr0), 64'd0);
      bus.Euler_Enable = 1'b0;
      @(negedge CLK);
      do_run(1, 0, 1'b0);
      chk("rerun_x0", mem[XB+0], 64'd5);

      // Reset during the write of element 1 of a four-element run.
      for (int i = 0; i < 4; i++) begin
         mem[XB+i]  = 64'(i + 1);
         mem[DXB+i] = 64'd8;
      end
      for (int i = 0; i < 4; i++) sbq.push_back('{a: Aw'(XB + i), d: 64'(i + 2)});
      @(negedge CLK);
      bus.Euler_Enable  = 1'b1;
      bus.Vector_Length = Aw'(4);
      bus.H_Shift       = 6'd3;
      k = 0;
      do begin
         @(negedge CLK);
         k++;
      end while (!(bus.WR_Enable && bus.WR_Address == Aw'(XB + 1)) && k < 50);
      chk("rst_reach_wr1", 64'(k < 50), 64'd1);
      RST = 1'b0;
      bus.Euler_Enable = 1'b0;
      #1;
      chk("abort_wren", 64'(bus.WR_Enable), 64'd0);
      chk("abort_wraddr", 64'(bus.WR_Address), 64'd0);
      chk("abort_rd2", 64'(bus.RD2_Address), 64'd0);
      sbq.delete();
      wr0 = wr_count;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      repeat (6) @(negedge CLK);
      chk("abort_no_wr", 64'(wr_count - wr0), 64'd0);
      chk("abort_x0", mem[XB+0], 64'd2);
      chk("abort_x1", mem[XB+1], 64'd2);
      chk("abort_x2", mem[XB+2], 64'd3);
      chk("abort_x3", mem[XB+3], 64'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
